// File: rtl/kf8088_interrupt_acknowledge_sequencer_if.sv
// -----------------------------------------------------------------------------
// kf8088_interrupt_acknowledge_sequencer_if
//
// Bundles the handshake and bus signals of the interrupt-acknowledge
// sequencer. Clock and reset stay plain module ports.
//
//   interrupt_request        INT from the KF8259
//   interrupt_enable         CPU IF flag (1 = maskable interrupts allowed)
//   instruction_boundary     1-cycle strobe: core can take an interrupt now
//   interrupt_acknowledge_n  INTA# to the KF8259, active low
//   bus_lock                 bus lock held for the whole acknowledge sequence
//   data_bus_in              PIC data bus, valid during the second INTA# pulse
//   vector                   captured interrupt vector
//   vector_valid             vector holds a delivered value
//   vector_accept            core consumes the vector
//   busy                     sequence in progress
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment (PIC + CPU core side) driving the sequencer
// -----------------------------------------------------------------------------
interface kf8088_interrupt_acknowledge_sequencer_if;
  logic       interrupt_request;
  logic       interrupt_enable;
  logic       instruction_boundary;
  logic       interrupt_acknowledge_n;
  logic       bus_lock;
  logic [7:0] data_bus_in;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vector_accept;
  logic       busy;

  modport slave (
    input  interrupt_request,
    input  interrupt_enable,
    input  instruction_boundary,
    input  data_bus_in,
    input  vector_accept,
    output interrupt_acknowledge_n,
    output bus_lock,
    output vector,
    output vector_valid,
    output busy
  );

  modport master (
    output interrupt_request,
    output interrupt_enable,
    output instruction_boundary,
    output data_bus_in,
    output vector_accept,
    input  interrupt_acknowledge_n,
    input  bus_lock,
    input  vector,
    input  vector_valid,
    input  busy
  );
endinterface

// File: rtl/kf8088_interrupt_acknowledge_sequencer.sv
// -----------------------------------------------------------------------------
// kf8088_interrupt_acknowledge_sequencer
//
// CPU-side initiator of the 8259 interrupt-acknowledge protocol. When the PIC
// raises INT while interrupts are enabled and the core signals an instruction
// boundary, it issues two INTA# pulses separated by a gap, holds the bus lock
// across the whole sequence, samples the vector byte at the end of the second
// pulse and offers it to the core with a valid/accept handshake.
//
// Ports:
//   clock  - system clock, rising-edge
//   reset  - synchronous, active-high
//   bus    - handshake/bus signals (slave modport of the interface)
//
// Parameters:
//   PULSE_CYCLES - cycles each INTA# low pulse lasts (1..15)
//   GAP_CYCLES   - cycles INTA# is high between the two pulses (1..15)
// -----------------------------------------------------------------------------
module kf8088_interrupt_acknowledge_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic clock,
  input  logic reset,
  kf8088_interrupt_acknowledge_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD
  } state_t;

  // The counter is loaded with (length - 1) on state entry and the state is
  // left on the cycle it reads zero, so each state lasts exactly `length`.
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] counter;
  logic       inta_n_q;
  logic       bus_lock_q;
  logic [7:0] vector_q;
  logic       vector_valid_q;
  logic       busy_q;

  // NOTE: all state and outputs live in one clocked block with non-blocking
  // assignments, so every output is a flop and reads the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= 4'd0;
      inta_n_q       <= 1'b1;
      bus_lock_q     <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Qualification is only looked at here; later changes of the
          // request, enable or boundary inputs cannot abort the sequence.
          if (bus.interrupt_request && bus.interrupt_enable &&
              bus.instruction_boundary) begin
            state      <= ACK1;
            counter    <= PULSE_LOAD;
            inta_n_q   <= 1'b0;
            bus_lock_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ACK1: begin
          if (counter == 4'd0) begin
            state    <= GAP;
            counter  <= GAP_LOAD;
            inta_n_q <= 1'b1;
          end else begin
            counter <= counter - 4'd1;
          end
        end

        GAP: begin
          if (counter == 4'd0) begin
            state    <= ACK2;
            counter  <= PULSE_LOAD;
            inta_n_q <= 1'b0;
          end else begin
            counter <= counter - 4'd1;
          end
        end

        ACK2: begin
          if (counter == 4'd0) begin
            // Capture on the edge closing the last low cycle: the PIC has had
            // the whole pulse to settle its vector onto the bus.
            state          <= HOLD;
            counter        <= 4'd0;
            vector_q       <= bus.data_bus_in;
            vector_valid_q <= 1'b1;
            inta_n_q       <= 1'b1;
            bus_lock_q     <= 1'b0;
          end else begin
            counter <= counter - 4'd1;
          end
        end

        HOLD: begin
          // Vector stays registered after the handshake; only valid drops.
          if (bus.vector_accept) begin
            state          <= IDLE;
            counter        <= 4'd0;
            vector_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          counter        <= 4'd0;
          inta_n_q       <= 1'b1;
          bus_lock_q     <= 1'b0;
          vector_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interrupt_acknowledge_n = inta_n_q;
  assign bus.bus_lock                = bus_lock_q;
  assign bus.vector                  = vector_q;
  assign bus.vector_valid            = vector_valid_q;
  assign bus.busy                    = busy_q;

endmodule

// File: doc/kf8088_interrupt_acknowledge_sequencer.md
Name: kf8088_interrupt_acknowledge_sequencer

Overview:
CPU-side initiator of the 8259 interrupt-acknowledge protocol. It watches the PIC's interrupt output and, when the CPU core allows it, generates the two INTA# pulses and locks the bus for the whole sequence. It captures the vector byte the PIC drives during the second pulse and hands that byte to the CPU core with a valid/accept handshake. It sits between the KF8259 interrupt output and the CPU core's interrupt entry logic.

Parameters:
PULSE_CYCLES, 4, clock cycles each INTA# low pulse lasts (legal range 1..15)
GAP_CYCLES, 2, clock cycles INTA# is high between the two pulses (legal range 1..15)

Ports:
clock  input  1  system clock; all logic is clocked on the rising edge
reset  input  1  synchronous, active-high reset
interrupt_request  input  1  INT output from the KF8259
interrupt_enable  input  1  CPU IF flag; 1 = maskable interrupts allowed
instruction_boundary  input  1  1-cycle strobe: the core can accept an interrupt this cycle
interrupt_acknowledge_n  output  1  INTA# to the KF8259, active low
bus_lock  output  1  bus lock, held for the whole acknowledge sequence
data_bus_in  input  8  PIC data bus, valid during the second INTA# pulse
vector  output  8  captured interrupt vector
vector_valid  output  1  vector is valid
vector_accept  input  1  core consumes the vector
busy  output  1  sequence in progress (state != IDLE)

Behaviour:
- Reset values: interrupt_acknowledge_n=1, bus_lock=0, vector=8'h00, vector_valid=0, busy=0, state=IDLE, counter=0. Reset mid-sequence aborts to IDLE on the next edge. No vector is delivered for an aborted sequence.
- States: IDLE, ACK1, GAP, ACK2, HOLD. All outputs are registered.
- IDLE -> ACK1: on an edge where interrupt_request & interrupt_enable & instruction_boundary = 1.
  - From the next cycle: interrupt_acknowledge_n=0, bus_lock=1, busy=1.
- ACK1: interrupt_acknowledge_n is low for exactly PULSE_CYCLES cycles, then the block enters GAP.
- GAP: interrupt_acknowledge_n=1 and bus_lock stays 1 for exactly GAP_CYCLES cycles, then the block enters ACK2.
- ACK2: interrupt_acknowledge_n is low for exactly PULSE_CYCLES cycles.
  - data_bus_in is sampled on the edge that ends the last ACK2 cycle.
  - On that same edge: vector<=sample, vector_valid<=1, interrupt_acknowledge_n<=1, bus_lock<=0, and the block enters HOLD.
- Latency: vector_valid rises 2*PULSE_CYCLES+GAP_CYCLES+1 cycles after the start edge (11 with defaults).
- HOLD: vector and vector_valid are stable until vector_accept=1. On that edge vector_valid<=0 and the block returns to IDLE; vector keeps its last value.
  - vector_accept outside HOLD is ignored.
  - A new sequence can start no earlier than the first IDLE cycle after the return, i.e. the edge after the accept edge.
- interrupt_request dropping after the start edge does not abort. Both pulses are generated and whatever data_bus_in holds is captured (the PIC supplies its spurious IR7 vector).
- interrupt_enable or instruction_boundary changing after the start edge is ignored.
- interrupt_request held high through HOLD does not restart the sequence. A restart needs a fresh qualifying instruction_boundary in IDLE.
- The counter is 4 bits, reloaded on every state entry. It never wraps inside a state.

Test Plan:
- Defaults; set interrupt_enable=1 and interrupt_request=1; pulse instruction_boundary at cycle T; data_bus_in=8'h0A during ACK2 -> interrupt_acknowledge_n low for T+1..T+4, high for T+5..T+6, low for T+7..T+10; bus_lock high for T+1..T+10; vector=8'h0A and vector_valid=1 at T+11.
- interrupt_enable=0 or no instruction_boundary, with interrupt_request=1 for 50 cycles -> interrupt_acknowledge_n stays 1, busy=0.
- Drop interrupt_request at T+2; data_bus_in=8'h0F -> both pulses still complete; vector=8'h0F.
- Hold vector_accept=0 for 20 cycles after vector_valid rises -> vector_valid and vector stable; a new instruction_boundary is ignored. Assert vector_accept -> vector_valid=0 next cycle; the next instruction_boundary starts a new sequence.
- Assert reset at T+8 (inside ACK2) -> next cycle interrupt_acknowledge_n=1, bus_lock=0, busy=0, vector_valid=0; no vector is delivered afterwards.
- PULSE_CYCLES=1, GAP_CYCLES=1 -> interrupt_acknowledge_n pattern is 0,1,0 on T+1..T+3; vector_valid=1 at T+4.
